// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the conditional-jump resolver: widths, condition codes,
// FSM state encoding and the flag-evaluation helpers.
package branch_resolver_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 16;
  localparam int CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    COND_JE     = 3'b000,
    COND_JNE    = 3'b001,
    COND_JA     = 3'b010,
    COND_JAE    = 3'b011,
    COND_JB     = 3'b100,
    COND_JBE    = 3'b101,
    COND_ALWAYS = 3'b110,
    COND_NEVER  = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_EVAL  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  function automatic logic flags_one_hot(input logic bigger, input logic equal,
                                         input logic smallest);
    return ({bigger, equal, smallest} == 3'b100) ||
           ({bigger, equal, smallest} == 3'b010) ||
           ({bigger, equal, smallest} == 3'b001);
  endfunction

  function automatic logic cond_taken(input cond_e cond, input logic bigger,
                                      input logic equal, input logic smallest);
    logic taken;
    taken = 1'b0;
    case (cond)
      COND_JE:     taken = equal;
      COND_JNE:    taken = !equal;
      COND_JA:     taken = bigger;
      COND_JAE:    taken = bigger | equal;
      COND_JB:     taken = smallest;
      COND_JBE:    taken = smallest | equal;
      COND_ALWAYS: taken = 1'b1;
      COND_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Request, result and comparator-side signals of the branch resolver.
// The slave modport is the resolver; the master side is the request source,
// result consumer and external comparator.
interface branch_resolver_if;
  import branch_resolver_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_cond;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [ADDR_W-1:0] req_pc;
  logic [DATA_W-1:0] req_disp;

  logic [DATA_W-1:0] cmp_a;
  logic [DATA_W-1:0] cmp_b;
  logic              cmp_bigger;
  logic              cmp_equal;
  logic              cmp_smallest;

  logic              res_valid;
  logic              res_ready;
  logic              res_taken;
  logic [ADDR_W-1:0] res_next_pc;
  logic              res_err;
  logic [CNT_W-1:0]  taken_cnt;

  modport master (
    output req_valid, req_cond, req_a, req_b, req_pc, req_disp,
    output res_ready, cmp_bigger, cmp_equal, cmp_smallest,
    input  req_ready, cmp_a, cmp_b, res_valid, res_taken, res_next_pc,
    input  res_err, taken_cnt
  );

  modport slave (
    input  req_valid, req_cond, req_a, req_b, req_pc, req_disp,
    input  res_ready, cmp_bigger, cmp_equal, cmp_smallest,
    output req_ready, cmp_a, cmp_b, res_valid, res_taken, res_next_pc,
    output res_err, taken_cnt
  );

endinterface

// File: rtl/branch_resolver.sv
// Resolves one conditional jump at a time: hands the operands to the external
// comparator, waits for its registered flags, then presents taken/next-pc.
module branch_resolver
  import branch_resolver_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  branch_resolver_if.slave  bus
);

  state_e            state;
  state_e            state_next;
  cond_e             cond_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] disp_q;
  logic              accept;
  logic              flags_ok;
  logic              taken_raw;
  logic [ADDR_W-1:0] target;

  assign accept = (state == ST_IDLE) && bus.req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (bus.req_valid) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_EVAL;
      ST_EVAL:  state_next = ST_DONE;
      ST_DONE:  if (bus.res_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Request fields and comparator operands only change on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_q    <= COND_JE;
      pc_q      <= '0;
      disp_q    <= '0;
      bus.cmp_a <= '0;
      bus.cmp_b <= '0;
    end else if (accept) begin
      cond_q    <= cond_e'(bus.req_cond);
      pc_q      <= bus.req_pc;
      disp_q    <= bus.req_disp;
      bus.cmp_a <= bus.req_a;
      bus.cmp_b <= bus.req_b;
    end
  end

  assign flags_ok  = flags_one_hot(bus.cmp_bigger, bus.cmp_equal, bus.cmp_smallest);
  assign taken_raw = cond_taken(cond_q, bus.cmp_bigger, bus.cmp_equal, bus.cmp_smallest);
  assign target    = pc_q + {{(ADDR_W-DATA_W){disp_q[DATA_W-1]}}, disp_q};

  // Corrupt flags suppress the jump even for the unconditional code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res_taken   <= 1'b0;
      bus.res_err     <= 1'b0;
      bus.res_next_pc <= '0;
    end else if (state == ST_EVAL) begin
      bus.res_err     <= !flags_ok;
      bus.res_taken   <= flags_ok && taken_raw;
      bus.res_next_pc <= (flags_ok && taken_raw) ? target : pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.taken_cnt <= '0;
    end else if ((state == ST_DONE) && bus.res_ready && bus.res_taken &&
                 (bus.taken_cnt != CNT_MAX)) begin
      bus.taken_cnt <= bus.taken_cnt + 1'b1;
    end
  end

  assign bus.req_ready = rst_n && (state == ST_IDLE);
  assign bus.res_valid = (state == ST_DONE);

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver with a behavioural registered comparator.
module tb_branch_resolver;
  import branch_resolver_pkg::*;

  typedef struct {
    logic        taken;
    logic [15:0] pc;
    logic        err;
    int          accept;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  logic prev_valid;
  logic force_en;
  logic [2:0] force_flags;

  branch_resolver_if bif ();

  branch_resolver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External comparator: flags registered one clock after sampling cmp_a/cmp_b.
  always @(posedge clk) begin
    if (force_en) begin
      {bif.cmp_bigger, bif.cmp_equal, bif.cmp_smallest} <= force_flags;
    end else begin
      bif.cmp_bigger   <= bif.cmp_a > bif.cmp_b;
      bif.cmp_equal    <= bif.cmp_a == bif.cmp_b;
      bif.cmp_smallest <= bif.cmp_a < bif.cmp_b;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on the rising edge of res_valid, contents at the handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (bif.res_valid && !prev_valid) begin
        if (exp_q.size() == 0) checkOutput("unexpected_result", 32'd1, 32'd0);
        else checkOutput("latency", cyc - exp_q[0].accept, 32'd2);
      end
      if (bif.res_valid && bif.res_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("res_taken", bif.res_taken, e.taken);
        checkOutput("res_next_pc", bif.res_next_pc, e.pc);
        checkOutput("res_err", bif.res_err, e.err);
      end
      prev_valid <= bif.res_valid;
    end
  end

  task automatic driveRequest(input logic [2:0] cond, input logic [7:0] a,
                              input logic [7:0] b, input logic [15:0] pc,
                              input logic [7:0] disp, input bit push,
                              input exp_t e_in);
    exp_t e;
    e = e_in;
    @(negedge clk);
    bif.req_cond  = cond;
    bif.req_a     = a;
    bif.req_b     = b;
    bif.req_pc    = pc;
    bif.req_disp  = disp;
    bif.req_valid = 1'b1;
    for (int i = 0; i < 64 && !bif.req_ready; i++) @(negedge clk);
    if (!bif.req_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      bif.req_valid = 1'b0;
      return;
    end
    e.accept = cyc + 1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bif.req_valid = 1'b0;
    checkOutput("cmp_a", bif.cmp_a, a);
    checkOutput("cmp_b", bif.cmp_b, b);
  endtask

  task automatic applyStimulus(input logic [2:0] cond, input logic [7:0] a,
                               input logic [7:0] b, input logic [15:0] pc,
                               input logic [7:0] disp, input logic exp_taken,
                               input logic [15:0] exp_pc, input logic exp_err);
    exp_t e;
    e.taken  = exp_taken;
    e.pc     = exp_pc;
    e.err    = exp_err;
    e.accept = 0;
    driveRequest(cond, a, b, pc, disp, 1'b1, e);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 64 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checkOutput("result_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    exp_t eb;
    logic        snap_taken;
    logic [15:0] snap_pc;
    logic        snap_err;
    checks        = 0;
    errors        = 0;
    force_en      = 1'b0;
    force_flags   = 3'b000;
    rst_n         = 1'b0;
    bif.req_valid = 1'b0;
    bif.req_cond  = 3'b000;
    bif.req_a     = 8'h00;
    bif.req_b     = 8'h00;
    bif.req_pc    = 16'h0000;
    bif.req_disp  = 8'h00;
    bif.res_ready = 1'b1;

    #12;
    checkOutput("rst_req_ready", bif.req_ready, 32'd0);
    checkOutput("rst_res_valid", bif.res_valid, 32'd0);
    checkOutput("rst_res_next_pc", bif.res_next_pc, 32'd0);
    checkOutput("rst_cmp_a", bif.cmp_a, 32'd0);
    checkOutput("rst_taken_cnt", bif.taken_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_req_ready", bif.req_ready, 32'd1);

    // Directed vectors with hand-computed results
    applyStimulus(COND_JE, 8'h5A, 8'h5A, 16'h1000, 8'h10, 1'b1, 16'h1010, 1'b0);
    waitIdle();
    checkOutput("taken_cnt_je", bif.taken_cnt, 32'd1);
    applyStimulus(COND_JA, 8'h80, 8'h7F, 16'h0005, 8'hF0, 1'b1, 16'hFFF5, 1'b0);
    applyStimulus(COND_JB, 8'h10, 8'h01, 16'h2000, 8'h20, 1'b0, 16'h2000, 1'b0);
    waitIdle();
    checkOutput("taken_cnt_jb", bif.taken_cnt, 32'd2);
    applyStimulus(COND_JNE, 8'h03, 8'h03, 16'h1234, 8'h7F, 1'b0, 16'h1234, 1'b0);
    applyStimulus(COND_JAE, 8'h07, 8'h07, 16'h0100, 8'h80, 1'b1, 16'h0080, 1'b0);
    applyStimulus(COND_JBE, 8'h01, 8'h02, 16'hFFF0, 8'h20, 1'b1, 16'h0010, 1'b0);
    applyStimulus(COND_NEVER, 8'h01, 8'h01, 16'h4000, 8'h05, 1'b0, 16'h4000, 1'b0);
    waitIdle();
    checkOutput("taken_cnt_mix", bif.taken_cnt, 32'd4);

    // Backpressure with a second request waiting
    bif.res_ready = 1'b0;
    applyStimulus(COND_ALWAYS, 8'h11, 8'h22, 16'h3000, 8'h04, 1'b1, 16'h3004, 1'b0);
    bif.req_cond  = COND_JA;
    bif.req_a     = 8'h02;
    bif.req_b     = 8'h09;
    bif.req_pc    = 16'h3100;
    bif.req_disp  = 8'h08;
    bif.req_valid = 1'b1;
    for (int i = 0; i < 20 && !bif.res_valid; i++) @(negedge clk);
    checkOutput("bp_res_valid", bif.res_valid, 32'd1);
    snap_taken = 1'b1;
    snap_pc    = 16'h3004;
    snap_err   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", bif.res_valid, 32'd1);
      checkOutput("bp_hold_taken", bif.res_taken, snap_taken);
      checkOutput("bp_hold_pc", bif.res_next_pc, snap_pc);
      checkOutput("bp_hold_err", bif.res_err, snap_err);
      checkOutput("bp_req_ready", bif.req_ready, 32'd0);
      checkOutput("bp_cmp_a", bif.cmp_a, 32'h11);
    end
    @(posedge clk);
    #1;
    bif.res_ready = 1'b1;
    eb.taken  = 1'b0;
    eb.pc     = 16'h3100;
    eb.err    = 1'b0;
    eb.accept = cyc + 2;
    exp_q.push_back(eb);
    @(posedge clk);
    #1;
    checkOutput("bp_ready_after_hs", bif.req_ready, 32'd1);
    checkOutput("bp_valid_after_hs", bif.res_valid, 32'd0);
    @(posedge clk);
    #1;
    bif.req_valid = 1'b0;
    checkOutput("bp_second_cmp_a", bif.cmp_a, 32'h02);
    waitIdle();
    checkOutput("taken_cnt_bp", bif.taken_cnt, 32'd5);

    // Non-one-hot flags under the unconditional code
    force_en    = 1'b1;
    force_flags = 3'b110;
    applyStimulus(COND_ALWAYS, 8'h44, 8'h33, 16'h5000, 8'h11, 1'b0, 16'h5000, 1'b1);
    waitIdle();
    force_en = 1'b0;
    checkOutput("taken_cnt_err", bif.taken_cnt, 32'd5);

    // Reset while the request sits in EVAL: discarded, no result ever appears
    eb.taken  = 1'b0;
    eb.pc     = 16'h0000;
    eb.err    = 1'b0;
    eb.accept = 0;
    driveRequest(COND_ALWAYS, 8'h01, 8'h02, 16'h6000, 8'h01, 1'b0, eb);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_res_valid", bif.res_valid, 32'd0);
    checkOutput("mid_rst_req_ready", bif.req_ready, 32'd0);
    checkOutput("mid_rst_taken_cnt", bif.taken_cnt, 32'd0);
    checkOutput("mid_rst_cmp_a", bif.cmp_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("mid_rel_req_ready", bif.req_ready, 32'd1);
    repeat (6) @(negedge clk);
    checkOutput("mid_rel_res_valid", bif.res_valid, 32'd0);

    // Counter saturation
    for (int i = 0; i < 255; i++)
      applyStimulus(COND_ALWAYS, 8'h00, 8'h01, 16'h7000, 8'h02, 1'b1, 16'h7002, 1'b0);
    waitIdle();
    checkOutput("taken_cnt_255", bif.taken_cnt, 32'd255);
    applyStimulus(COND_ALWAYS, 8'h00, 8'h01, 16'h7000, 8'hFE, 1'b1, 16'h6FFE, 1'b0);
    waitIdle();
    checkOutput("taken_cnt_sat", bif.taken_cnt, 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 req_valid  input  1  conditional-jump request present.
REQ-004 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-005 req_cond  input  3  condition code: 000 JE, 001 JNE, 010 JA, 011 JAE, 100 JB, 101 JBE, 110 always, 111 never.
REQ-006 req_a, req_b  input  8 each  unsigned operands to compare.
REQ-007 req_pc  input  16  address of next sequential instruction.
REQ-008 req_disp  input  8  signed two's-complement displacement.
REQ-009 cmp_a, cmp_b  output  8 each  registered operands driven to the external comparator.
REQ-010 cmp_bigger, cmp_equal, cmp_smallest  input  1 each  comparator flags, registered by the comparator one clk after sampling cmp_a/cmp_b.
REQ-011 res_valid  output  1  resolution result present.
REQ-012 res_ready  input  1  consumer accepts result.
REQ-013 res_taken  output  1  branch taken.
REQ-014 res_next_pc  output  16  redirect address.
REQ-015 res_err  output  1  comparator flags were not one-hot.
REQ-016 taken_cnt  output  8  saturating count of taken branches.

Function
REQ-017 FSM states: IDLE, ISSUE, EVAL, DONE; encoding from shared package.
REQ-018 IDLE: req_ready=1; on req_valid=1, latch req_cond, req_pc, req_disp; load req_a/req_b into cmp_a/cmp_b; go to ISSUE.
REQ-019 ISSUE: hold cmp_a/cmp_b stable; unconditionally go to EVAL after one cycle.
REQ-020 EVAL: sample comparator flags; compute and register res_taken, res_next_pc, res_err; go to DONE.
REQ-021 DONE: res_valid=1; hold all res_* stable until res_ready=1; on handshake go to IDLE.
REQ-022 Latency: res_valid rises at the second rising edge after the accepting edge; peak throughput one request per 4 cycles.
REQ-023 Taken rules: JE=equal; JNE=!equal; JA=bigger; JAE=bigger|equal; JB=smallest; JBE=smallest|equal; 110=1; 111=0.
REQ-024 res_next_pc = req_pc + sign-extended req_disp, modulo 2^16, when taken; req_pc when not taken.
REQ-025 Flags not exactly one-hot: res_err=1, res_taken=0, res_next_pc=req_pc, for every condition code including 110.
REQ-026 taken_cnt increments by 1 on each res_valid&&res_ready with res_taken=1; saturates at 255.
REQ-027 req_valid outside IDLE is ignored; no request is queued.
REQ-028 cmp_a/cmp_b retain their last values outside IDLE-accept.

Reset
REQ-029 rst_n=0 forces IDLE immediately, regardless of clk; any in-flight request is discarded.
REQ-030 Reset values: req_ready=0 while rst_n=0 and 1 after release, res_valid=0, res_taken=0, res_err=0, res_next_pc=0, cmp_a=0, cmp_b=0, taken_cnt=0.

Structure
REQ-031 Shared package holds condition-code constants, FSM state encodings, and widths (data 8, address 16).
REQ-032 Single module, no sub-module; the comparator stays an external peer wired through cmp_* ports.

Verification
REQ-033 JE: a=0x5A, b=0x5A, pc=0x1000, disp=0x10 -> res_valid after 2 edges, taken=1, next_pc=0x1010, taken_cnt=1.
REQ-034 JA with wrap: a=0x80, b=0x7F, pc=0x0005, disp=0xF0 (-16) -> taken=1, next_pc=0xFFF5.
REQ-035 JB not taken: a=0x10, b=0x01, pc=0x2000 -> taken=0, next_pc=0x2000, taken_cnt unchanged.
REQ-036 Backpressure: hold res_ready=0 for 5 cycles with new req_valid=1 -> res_* stable, req_ready=0, second request accepted only in the cycle after the handshake.
REQ-037 Forced flags 1,1,0 under cond 110 -> res_err=1, taken=0, next_pc=pc.
REQ-038 rst_n low during EVAL -> res_valid=0 and IDLE before next edge; 256 taken branches -> taken_cnt=255.
